// File: rtl/axi_pkg.sv
// Shared AXI3 constants and read-arbiter types for the cache-to-AXI master port.
package axi_pkg;

  localparam logic [1:0] BURST_INCR   = 2'b01;
  localparam logic [3:0] INST_ID_DEF  = 4'd0;
  localparam logic [3:0] DATA_ID_DEF  = 4'd1;
  localparam int         STREAK_LIMIT = 4;

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA} rd_state_t;
  typedef enum logic {GNT_INST = 1'b0, GNT_DATA = 1'b1} grant_t;

endpackage

// File: rtl/wr_tracker.sv
// Counts accepted-but-unacknowledged write bursts and closes the AW gate when full.
module wr_tracker #(
  parameter int MAX_WR_OUT = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            aw_req_i,
  input  logic                            aw_ready_i,
  input  logic                            b_fire_i,
  output logic                            aw_gate_o,
  output logic [$clog2(MAX_WR_OUT+1)-1:0] cnt_o
);

  localparam int CW = $clog2(MAX_WR_OUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          aw_fire;

  assign aw_gate_o = (cnt_q < CW'(MAX_WR_OUT));
  assign aw_fire   = aw_req_i & aw_ready_i & aw_gate_o;
  assign cnt_o     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (aw_fire && !b_fire_i)      cnt_d = cnt_q + 1'b1;
    else if (!aw_fire && b_fire_i) cnt_d = cnt_q - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // A response with nothing outstanding means the slave invented a write.
  no_underflow: assert property (@(posedge clk) disable iff (rst) b_fire_i |-> (cnt_q != '0));

endmodule

// File: rtl/axi_mem_arbiter.sv
// Shares one AXI3 master between the I-cache (reads) and D-cache (reads + writes).
module axi_mem_arbiter
  import axi_pkg::*;
#(
  parameter int         MAX_WR_OUT = 4,
  parameter logic [3:0] INST_ID    = INST_ID_DEF,
  parameter logic [3:0] DATA_ID    = DATA_ID_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic        i_arvalid,
  output logic        i_arready,
  output logic [31:0] i_rdata,
  output logic        i_rlast,
  output logic        i_rvalid,
  input  logic        i_rready,
  input  logic [31:0] d_araddr,
  input  logic [7:0]  d_arlen,
  input  logic [2:0]  d_arsize,
  input  logic        d_arvalid,
  output logic        d_arready,
  output logic [31:0] d_rdata,
  output logic        d_rlast,
  output logic        d_rvalid,
  input  logic        d_rready,
  input  logic [31:0] d_awaddr,
  input  logic [7:0]  d_awlen,
  input  logic [2:0]  d_awsize,
  input  logic        d_awvalid,
  output logic        d_awready,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  input  logic        d_wlast,
  input  logic        d_wvalid,
  output logic        d_wready,
  output logic        d_bvalid,
  input  logic        d_bready,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  localparam int CW = $clog2(MAX_WR_OUT + 1);

  rd_state_t     state_q;
  grant_t        grant_q;
  logic          arvalid_q, i_arready_q, d_arready_q;
  logic [2:0]    streak_q;
  logic [31:0]   addr_q;
  logic [7:0]    len_q;
  logic [2:0]    size_q;
  logic [CW-1:0] wr_cnt;
  logic          aw_gate, d_blocked, starve, take_data, take_inst, in_data;
  logic          unused_sigs;

  wr_tracker #(.MAX_WR_OUT(MAX_WR_OUT)) u_wr (
    .clk        (clk),
    .rst        (rst),
    .aw_req_i   (d_awvalid),
    .aw_ready_i (awready),
    .b_fire_i   (bvalid & d_bready),
    .aw_gate_o  (aw_gate),
    .cnt_o      (wr_cnt)
  );

  // A data read must not pass a writeback still in flight or being offered.
  assign d_blocked = (wr_cnt != '0) || d_awvalid;
  assign starve    = (streak_q >= 3'(STREAK_LIMIT)) && i_arvalid;
  assign take_data = d_arvalid && !d_blocked && !starve;
  assign take_inst = i_arvalid && !take_data;
  assign in_data   = (state_q == R_DATA);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= R_IDLE;
      grant_q     <= GNT_INST;
      arvalid_q   <= 1'b0;
      i_arready_q <= 1'b0;
      d_arready_q <= 1'b0;
      streak_q    <= '0;
    end else begin
      i_arready_q <= 1'b0;
      d_arready_q <= 1'b0;
      case (state_q)
        R_IDLE: begin
          if (take_data || take_inst) begin
            state_q   <= R_AR;
            arvalid_q <= 1'b1;
            grant_q   <= take_data ? GNT_DATA : GNT_INST;
            if (take_data) streak_q <= i_arvalid ? streak_q + 3'd1 : 3'd0;
            else           streak_q <= '0;
          end
        end
        R_AR: begin
          if (arready) begin
            state_q     <= R_DATA;
            arvalid_q   <= 1'b0;
            i_arready_q <= (grant_q == GNT_INST);
            d_arready_q <= (grant_q == GNT_DATA);
          end
        end
        R_DATA: begin
          if (rvalid && rready && rlast) state_q <= R_IDLE;
        end
        default: state_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == R_IDLE) begin
      addr_q <= take_data ? d_araddr : i_araddr;
      len_q  <= take_data ? d_arlen  : i_arlen;
      size_q <= take_data ? d_arsize : i_arsize;
    end
  end

  assign arid      = (grant_q == GNT_DATA) ? DATA_ID : INST_ID;
  assign araddr    = addr_q;
  assign arlen     = len_q;
  assign arsize    = size_q;
  assign arburst   = BURST_INCR;
  assign arlock    = 2'b00;
  assign arcache   = 4'h0;
  assign arprot    = 3'h0;
  assign arvalid   = arvalid_q;
  assign i_arready = i_arready_q;
  assign d_arready = d_arready_q;

  assign rready    = in_data && ((grant_q == GNT_DATA) ? d_rready : i_rready);
  assign i_rvalid  = in_data && (grant_q == GNT_INST) && rvalid;
  assign d_rvalid  = in_data && (grant_q == GNT_DATA) && rvalid;
  assign i_rdata   = rdata;
  assign d_rdata   = rdata;
  assign i_rlast   = rlast;
  assign d_rlast   = rlast;

  assign awid      = DATA_ID;
  assign awaddr    = d_awaddr;
  assign awlen     = d_awlen;
  assign awsize    = d_awsize;
  assign awburst   = BURST_INCR;
  assign awlock    = 2'b00;
  assign awcache   = 4'h0;
  assign awprot    = 3'h0;
  assign awvalid   = d_awvalid & aw_gate;
  assign d_awready = awready & aw_gate;
  assign wid       = DATA_ID;
  assign wdata     = d_wdata;
  assign wstrb     = d_wstrb;
  assign wlast     = d_wlast;
  assign wvalid    = d_wvalid;
  assign d_wready  = wready;
  assign d_bvalid  = bvalid;
  assign bready    = d_bready;

  assign unused_sigs = ^{rresp, bresp, bid, rid};

  rid_match: assert property (@(posedge clk) disable iff (rst)
    (in_data && rvalid) |-> (rid == ((grant_q == GNT_DATA) ? DATA_ID : INST_ID)));

endmodule

// File: tb/tb_axi_mem_arbiter.sv
// Directed and randomized bench for axi_mem_arbiter with a grant-order reference model.
module tb_axi_mem_arbiter;
  import axi_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_araddr, d_araddr, araddr, i_rdata, d_rdata, rdata, d_awaddr, awaddr, d_wdata, wdata;
  logic [7:0]  i_arlen, d_arlen, arlen, d_awlen, awlen;
  logic [2:0]  i_arsize, d_arsize, arsize, d_awsize, awsize, arprot, awprot;
  logic        i_arvalid, i_arready, i_rlast, i_rvalid, i_rready;
  logic        d_arvalid, d_arready, d_rlast, d_rvalid, d_rready;
  logic        d_awvalid, d_awready, d_wlast, d_wvalid, d_wready, d_bvalid, d_bready;
  logic        arvalid, arready, rlast, rvalid, rready, awvalid, awready;
  logic        wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  d_wstrb, wstrb, arid, rid, awid, wid, bid, arcache, awcache;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;

  int checks = 0;
  int errors = 0;
  int ipulse = 0;
  int dpulse = 0;
  int wr_out = 0;
  int streak = 0;

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (i_arready) ipulse++;
    if (d_arready) dpulse++;
  end

  axi_mem_arbiter #(.MAX_WR_OUT(4), .INST_ID(4'd0), .DATA_ID(4'd1)) dut (
    .clk(clk), .rst(rst),
    .i_araddr(i_araddr), .i_arlen(i_arlen), .i_arsize(i_arsize), .i_arvalid(i_arvalid),
    .i_arready(i_arready), .i_rdata(i_rdata), .i_rlast(i_rlast), .i_rvalid(i_rvalid), .i_rready(i_rready),
    .d_araddr(d_araddr), .d_arlen(d_arlen), .d_arsize(d_arsize), .d_arvalid(d_arvalid),
    .d_arready(d_arready), .d_rdata(d_rdata), .d_rlast(d_rlast), .d_rvalid(d_rvalid), .d_rready(d_rready),
    .d_awaddr(d_awaddr), .d_awlen(d_awlen), .d_awsize(d_awsize), .d_awvalid(d_awvalid), .d_awready(d_awready),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb), .d_wlast(d_wlast), .d_wvalid(d_wvalid), .d_wready(d_wready),
    .d_bvalid(d_bvalid), .d_bready(d_bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst), .awlock(awlock),
    .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Data wins unless writes are in flight/offered or the I-side was passed over four times running.
  function automatic bit model_pick_data(bit ip, bit dp, bit blocked, int stk);
    return dp && !blocked && !(ip && stk >= 4);
  endfunction

  // Plays the AXI slave for one read burst and checks AR contents, pulse and beat routing.
  task automatic serve(input bit exp_data, input int ar_delay, input bit stall, output int wait_cyc);
    logic [3:0]  exp_id;
    logic [31:0] ea, dat;
    logic [7:0]  el;
    logic [2:0]  es;
    int          ip0, dp0;
    bit          ipend, b_now;
    ipend  = i_arvalid;
    exp_id = exp_data ? 4'd1 : 4'd0;
    ea     = exp_data ? d_araddr : i_araddr;
    el     = exp_data ? d_arlen  : i_arlen;
    es     = exp_data ? d_arsize : i_arsize;
    ip0    = ipulse;
    dp0    = dpulse;
    wait_cyc = 0;
    while (!arvalid && wait_cyc < 50) begin
      step();
      wait_cyc++;
    end
    chk("ar_seen", arvalid, 1);
    chk("arid", arid, exp_id);
    chk("araddr", araddr, ea);
    chk("arlen", arlen, el);
    chk("arsize", arsize, es);
    for (int k = 0; k < ar_delay; k++) begin
      step();
      chk("ar_hold", arvalid, 1);
    end
    arready = 1'b1;
    step();
    arready = 1'b0;
    chk("ar_drop", arvalid, 0);
    if (exp_data) d_arvalid = 1'b0;
    else          i_arvalid = 1'b0;
    if (exp_data) streak = ipend ? streak + 1 : 0;
    else          streak = 0;
    for (int b = 0; b <= int'(el); b++) begin
      dat    = $urandom;
      rvalid = 1'b1;
      rid    = exp_id;
      rdata  = dat;
      rlast  = (b == int'(el));
      rresp  = 2'($urandom_range(0, 3));
      b_now  = (b == 0) && (wr_out > 0);
      if (b_now) begin
        bvalid   = 1'b1;
        d_bready = 1'b1;
      end
      if (stall && $urandom_range(0, 1) == 1) begin
        if (exp_data) d_rready = 1'b0;
        else          i_rready = 1'b0;
        #1;
        chk("rready_stall", rready, 0);
        step();
        if (b_now) begin
          bvalid   = 1'b0;
          d_bready = 1'b0;
          wr_out--;
          b_now    = 1'b0;
        end
        d_rready = 1'b1;
        i_rready = 1'b1;
      end
      #1;
      chk("rvalid_win", exp_data ? d_rvalid : i_rvalid, 1);
      chk("rvalid_other", exp_data ? i_rvalid : d_rvalid, 0);
      chk("rdata", exp_data ? d_rdata : i_rdata, dat);
      chk("rlast", exp_data ? d_rlast : i_rlast, rlast);
      chk("rready", rready, 1);
      step();
      if (b_now) begin
        bvalid   = 1'b0;
        d_bready = 1'b0;
        wr_out--;
      end
    end
    rvalid = 1'b0;
    rlast  = 1'b0;
    chk("ar_pulse_i", ipulse - ip0, exp_data ? 0 : 1);
    chk("ar_pulse_d", dpulse - dp0, exp_data ? 1 : 0);
  endtask

  initial begin
    int wc;
    bit wd;
    bit exp_order [5];
    {i_araddr, i_arlen, i_arsize, i_arvalid, d_araddr, d_arlen, d_arsize, d_arvalid} = '0;
    {d_awaddr, d_awlen, d_awsize, d_awvalid, d_wdata, d_wstrb, d_wlast, d_wvalid, d_bready} = '0;
    {arready, rid, rdata, rresp, rlast, rvalid, awready, wready, bid, bresp, bvalid} = '0;
    i_rready = 1'b1;
    d_rready = 1'b1;
    rst      = 1'b1;
    i_arvalid = 1'b1;
    rvalid    = 1'b1;
    step();
    step();
    chk("rst_outs", {arvalid, i_arready, d_arready, i_rvalid, d_rvalid, rready}, 6'h0);
    chk("rst_state", dut.state_q, R_IDLE);
    chk("rst_cnt", dut.wr_cnt, 0);
    chk("rst_grant", dut.grant_q, GNT_INST);
    chk("consts", {arburst, awburst, arlock, awlock, arcache, awcache, arprot, awprot, awid, wid},
        {2'b01, 2'b01, 2'b00, 2'b00, 4'h0, 4'h0, 3'h0, 3'h0, 4'd1, 4'd1});
    i_arvalid = 1'b0;
    rvalid    = 1'b0;
    rst       = 1'b0;
    step();

    // Instruction-only burst of 8 beats, AR accepted after two cycles.
    i_araddr = 32'h1FC0_0000; i_arlen = 8'd7; i_arsize = 3'd2; i_arvalid = 1'b1;
    serve(1'b0, 2, 1'b0, wc);
    chk("t1_wait", wc, 1);
    chk("t1_idle", dut.state_q, R_IDLE);

    // Simultaneous requests: data first, instruction straight after its rlast.
    i_araddr = 32'h0000_1000; i_arlen = 8'd3; i_arsize = 3'd2; i_arvalid = 1'b1;
    d_araddr = 32'h8000_0040; d_arlen = 8'd1; d_arsize = 3'd2; d_arvalid = 1'b1;
    serve(1'b1, 0, 1'b0, wc);
    serve(1'b0, 1, 1'b0, wc);
    chk("t2_inst_next", wc, 1);

    // An offered write address blocks the data read; instruction goes instead.
    d_awaddr = 32'h8000_2000; d_awvalid = 1'b1;
    i_araddr = 32'h0000_2000; i_arlen = 8'd0; i_arvalid = 1'b1;
    d_araddr = 32'h8000_2000; d_arlen = 8'd2; d_arvalid = 1'b1;
    serve(1'b0, 0, 1'b0, wc);
    d_awvalid = 1'b0;
    serve(1'b1, 0, 1'b1, wc);

    // Outstanding write holds off a data read until its response.
    d_awaddr = 32'h8000_3000; d_awlen = 8'd3; d_awsize = 3'd2; d_awvalid = 1'b1; awready = 1'b1;
    #1;
    chk("aw_pass", {awvalid, d_awready, awaddr, awlen}, {1'b1, 1'b1, 32'h8000_3000, 8'd3});
    step();
    wr_out++;
    d_awvalid = 1'b0; awready = 1'b0;
    d_wdata = $urandom; d_wstrb = 4'hA; d_wlast = 1'b1; d_wvalid = 1'b1; wready = 1'b1;
    #1;
    chk("w_pass", {wvalid, wdata, wstrb, wlast, d_wready}, {1'b1, d_wdata, 4'hA, 1'b1, 1'b1});
    step();
    d_wvalid = 1'b0; wready = 1'b0; d_wlast = 1'b0;
    d_araddr = 32'h8000_3000; d_arlen = 8'd3; d_arvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_blocked", arvalid, 0);
    end
    chk("t3_cnt", dut.wr_cnt, wr_out);
    bvalid = 1'b1; bid = 4'd1; d_bready = 1'b1;
    #1;
    chk("b_pass", {d_bvalid, bready}, 2'b11);
    step();
    wr_out--;
    bvalid = 1'b0; d_bready = 1'b0;
    chk("t3_still_low", arvalid, 0);
    step();
    chk("t3_ar_next", arvalid, 1);
    serve(1'b1, 0, 1'b1, wc);

    // Fill the write window, then one response reopens it.
    for (int k = 0; k < 4; k++) begin
      d_awaddr = $urandom; d_awvalid = 1'b1; awready = 1'b1;
      #1;
      chk("t4_aw_open", awvalid, 1);
      step();
      wr_out++;
    end
    #1;
    chk("t4_full_awvalid", awvalid, 0);
    chk("t4_full_awready", d_awready, 0);
    step();
    chk("t4_cnt_hold", dut.wr_cnt, wr_out);
    bvalid = 1'b1; d_bready = 1'b1;
    step();
    wr_out--;
    bvalid = 1'b0; d_bready = 1'b0;
    #1;
    chk("t4_reopen", {awvalid, d_awready}, 2'b11);
    step();
    wr_out++;
    chk("t4_cnt_full", dut.wr_cnt, wr_out);
    awready = 1'b0; d_awvalid = 1'b0;
    bvalid = 1'b1; d_bready = 1'b1;
    step();
    wr_out--;
    d_awvalid = 1'b1; awready = 1'b1;
    step();
    d_awvalid = 1'b0; awready = 1'b0;
    chk("t4_inc_dec", dut.wr_cnt, wr_out);
    while (wr_out > 0) begin
      step();
      wr_out--;
    end
    bvalid = 1'b0; d_bready = 1'b0;
    chk("t4_drained", dut.wr_cnt, 0);

    // Continuous data traffic must let the waiting instruction in after four grants.
    exp_order = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    i_araddr = 32'h0000_5000; i_arlen = 8'd1; i_arvalid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (!d_arvalid) begin
        d_araddr = 32'h8000_5000 + 32'(k * 64); d_arlen = 8'(k % 3); d_arvalid = 1'b1;
      end
      serve(exp_order[k], 0, 1'b0, wc);
    end
    serve(1'b1, 0, 1'b0, wc);

    // Reset in the middle of an 8-beat burst.
    i_araddr = 32'h1FC0_0100; i_arlen = 8'd7; i_arvalid = 1'b1;
    step();
    chk("t6_ar", arvalid, 1);
    arready = 1'b1;
    step();
    arready = 1'b0; i_arvalid = 1'b0;
    for (int b = 0; b < 3; b++) begin
      rvalid = 1'b1; rid = 4'd0; rlast = 1'b0; rdata = $urandom;
      #1;
      chk("t6_beat", i_rvalid, 1);
      step();
    end
    rvalid = 1'b1;
    #1;
    rst = 1'b1;
    #1;
    chk("t6_rst_valids", {i_rvalid, d_rvalid, arvalid, rready, i_arready, d_arready}, 6'h0);
    chk("t6_rst_state", dut.state_q, R_IDLE);
    step();
    rst = 1'b0;
    streak = 0;
    wr_out = 0;
    #1;
    chk("t6_no_beat", {i_rvalid, d_rvalid, rready}, 3'h0);
    step();
    chk("t6_no_beat2", {i_rvalid, d_rvalid, rready}, 3'h0);
    rvalid = 1'b0;
    i_araddr = 32'h1FC0_0200; i_arlen = 8'd2; i_arvalid = 1'b1;
    serve(1'b0, 1, 1'b0, wc);

    // Random traffic against the grant model, sometimes with a write in flight.
    for (int r = 0; r < 30; r++) begin
      if ($urandom_range(0, 3) == 0 && wr_out == 0) begin
        d_awaddr = $urandom; d_awvalid = 1'b1; awready = 1'b1;
        step();
        wr_out++;
        d_awvalid = 1'b0; awready = 1'b0;
        if (!i_arvalid) begin
          i_araddr = $urandom; i_arlen = 8'($urandom_range(0, 3)); i_arsize = 3'($urandom_range(0, 2));
          i_arvalid = 1'b1;
        end
      end
      if (!i_arvalid && $urandom_range(0, 2) != 0) begin
        i_araddr = $urandom; i_arlen = 8'($urandom_range(0, 3)); i_arsize = 3'($urandom_range(0, 2));
        i_arvalid = 1'b1;
      end
      if (!d_arvalid && $urandom_range(0, 2) != 0) begin
        d_araddr = $urandom; d_arlen = 8'($urandom_range(0, 3)); d_arsize = 3'($urandom_range(0, 2));
        d_arvalid = 1'b1;
      end
      if (!i_arvalid && !d_arvalid) begin
        d_araddr = $urandom; d_arlen = 8'($urandom_range(0, 3)); d_arsize = 3'd2;
        d_arvalid = (wr_out == 0);
        i_arvalid = (wr_out != 0);
      end
      wd = model_pick_data(i_arvalid, d_arvalid, (wr_out != 0) || d_awvalid, streak);
      serve(wd, $urandom_range(0, 2), 1'b1, wc);
    end
    chk("rand_cnt_end", dut.wr_cnt, wr_out);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
